// File: rtl/gfx_pkg.sv
// Shared graphics types and constants.
// Arbiter states, VRAM geometry, triangle records.
package gfx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_RENDER
  } arb_state_t;

  localparam int VRAM_SIZE      = 256;
  localparam int VRAM_ADDR_BITS = $clog2(VRAM_SIZE);
  localparam int DISPLAY_WIDTH  = 640;
  localparam int DISPLAY_HEIGHT = 480;

  typedef struct packed {
    logic [15:0] x0;
    logic [15:0] y0;
    logic [15:0] x1;
    logic [15:0] y1;
    logic [15:0] x2;
    logic [15:0] y2;
  } triangle_t;

  localparam int TRI_BITS = $bits(triangle_t);
  localparam int PAD_BITS = 128;

  typedef logic [PAD_BITS-1:0] padded_triangle_t;

  function automatic triangle_t unpad_tri(
    input padded_triangle_t p
  );
    return triangle_t'(p[TRI_BITS-1:0]);
  endfunction

endpackage

// File: rtl/vram_write_arbiter_if.sv
// Producer-side write request bundle.
// Requester i owns slice i of addr/data.
interface vram_write_arbiter_if #(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 96
);

  logic [NUM_REQ-1:0]           valid;
  logic [NUM_REQ*ADDR_BITS-1:0] addr;
  logic [NUM_REQ*DATA_BITS-1:0] data;
  logic [NUM_REQ-1:0]           ready;

  modport master (
    output valid,
    output addr,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  addr,
    input  data,
    output ready
  );

endinterface

// File: rtl/vram_write_arbiter_rr_grant.sv
// Combinational round-robin picker.
// First set req bit searching circularly from ptr.
module rr_grant #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  logic found;
  int   k;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int o = 0; o < N; o++) begin
      k = (int'(ptr) + o) % N;
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = PW'(k);
      end
    end
  end

endmodule

// File: rtl/vram_write_arbiter.sv
// VRAM write port owner: round-robin writes,
// gated off while a frame renders.
module vram_write_arbiter
  import gfx_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 96,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int CNT_BITS       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vram_write_arbiter_if.slave  req,
  input  logic                 frame_req,
  output logic                 frame_start,
  input  logic                 frame_done,
  output logic                 render_busy,
  output logic                 vram_wr_en,
  output logic [ADDR_BITS-1:0] vram_wr_addr,
  output logic [DATA_BITS-1:0] vram_wr_data,
  output logic [CNT_BITS-1:0]  dropped_frames,
  output logic                 render_timeout
);

  localparam int PW =
    (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST =
    TW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] P_LAST =
    PW'(NUM_REQ - 1);

  arb_state_t         state;
  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic               frame_pending;
  logic [TW-1:0]      timer;
  logic               grant_ok;
  logic               accept;
  logic               drop;

  rr_grant #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr (
    .req (req.valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign grant_ok  = (state == ST_IDLE) && !frame_pending;
  assign req.ready = grant_ok ? gnt : '0;
  assign accept    = |(req.valid & req.ready);

  // A request landing in START queues the next frame, never a drop.
  assign drop = frame_req && frame_pending
             && (state != ST_START)
             && (dropped_frames != '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      rr_ptr         <= '0;
      frame_pending  <= 1'b0;
      timer          <= '0;
      frame_start    <= 1'b0;
      render_busy    <= 1'b0;
      vram_wr_en     <= 1'b0;
      vram_wr_addr   <= '0;
      vram_wr_data   <= '0;
      dropped_frames <= '0;
      render_timeout <= 1'b0;
    end else begin
      vram_wr_en  <= accept;
      frame_start <= 1'b0;
      if (accept) begin
        vram_wr_addr <=
          req.addr[gnt_idx*ADDR_BITS +: ADDR_BITS];
        vram_wr_data <=
          req.data[gnt_idx*DATA_BITS +: DATA_BITS];
      end
      if (drop) begin
        dropped_frames <= dropped_frames + 1'b1;
      end
      unique case (state)
        ST_IDLE: begin
          frame_pending <= frame_pending | frame_req;
          if (frame_pending) begin
            state       <= ST_START;
            frame_start <= 1'b1;
          end else if (accept) begin
            rr_ptr <= (gnt_idx == P_LAST)
                    ? '0 : gnt_idx + 1'b1;
          end
        end
        ST_START: begin
          frame_pending <= frame_req;
          timer         <= '0;
          state         <= ST_RENDER;
          render_busy   <= 1'b1;
        end
        ST_RENDER: begin
          frame_pending <= frame_pending | frame_req;
          timer         <= timer + 1'b1;
          if (frame_done) begin
            state       <= ST_IDLE;
            render_busy <= 1'b0;
          end else if (timer == T_LAST) begin
            state          <= ST_IDLE;
            render_busy    <= 1'b0;
            render_timeout <= 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          render_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Randomized bench for vram_write_arbiter
// against a cycle-level behavioural model.
module tb_vram_write_arbiter;

  localparam int N  = 3;
  localparam int AB = 8;
  localparam int DB = 96;
  localparam int TO = 16;
  localparam int CB = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_req;
  logic          frame_done;
  logic          frame_start;
  logic          render_busy;
  logic          vram_wr_en;
  logic [AB-1:0] vram_wr_addr;
  logic [DB-1:0] vram_wr_data;
  logic [CB-1:0] dropped_frames;
  logic          render_timeout;

  always #5 clk = ~clk;

  vram_write_arbiter_if #(
    .NUM_REQ   (N),
    .ADDR_BITS (AB),
    .DATA_BITS (DB)
  ) bus ();

  vram_write_arbiter #(
    .NUM_REQ        (N),
    .ADDR_BITS      (AB),
    .DATA_BITS      (DB),
    .TIMEOUT_CYCLES (TO),
    .CNT_BITS       (CB)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (bus),
    .frame_req      (frame_req),
    .frame_start    (frame_start),
    .frame_done     (frame_done),
    .render_busy    (render_busy),
    .vram_wr_en     (vram_wr_en),
    .vram_wr_addr   (vram_wr_addr),
    .vram_wr_data   (vram_wr_data),
    .dropped_frames (dropped_frames),
    .render_timeout (render_timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  // 0 = idle, 1 = start, 2 = render
  int            m_phase;
  int            m_ptr;
  int            m_timer;
  int            m_drop;
  bit            m_pend;
  bit            m_start;
  bit            m_busy;
  bit            m_wen;
  bit            m_tmo;
  logic [AB-1:0] m_waddr;
  logic [DB-1:0] m_wdata;

  function automatic void model_reset();
    m_phase = 0;
    m_ptr   = 0;
    m_timer = 0;
    m_drop  = 0;
    m_pend  = 0;
    m_start = 0;
    m_busy  = 0;
    m_wen   = 0;
    m_tmo   = 0;
    m_waddr = '0;
    m_wdata = '0;
  endfunction

  task automatic step(
    input logic [N-1:0] v,
    input bit           fr,
    input bit           fd
  );
    int            g;
    int            ph;
    bit            pd;
    logic [N-1:0]  er;
    bus.valid  = v;
    bus.addr   = {$urandom, $urandom};
    bus.data   = {$urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom};
    frame_req  = fr;
    frame_done = fd;
    #4;
    g  = -1;
    er = '0;
    if (m_phase == 0 && !m_pend) begin
      for (int o = N - 1; o >= 0; o--) begin
        if (v[(m_ptr + o) % N]) g = (m_ptr + o) % N;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    check("ready", bus.ready, er);
    check("wr_en", vram_wr_en, m_wen);
    if (m_wen) begin
      check("wr_addr", vram_wr_addr, m_waddr);
      check("wr_data", vram_wr_data, m_wdata);
    end
    check("frame_start", frame_start, m_start);
    check("render_busy", render_busy, m_busy);
    check("dropped", dropped_frames, m_drop);
    check("timeout", render_timeout, m_tmo);
    ph    = m_phase;
    pd    = m_pend;
    m_wen = (g >= 0);
    if (m_wen) begin
      m_waddr = bus.addr[g*AB +: AB];
      m_wdata = bus.data[g*DB +: DB];
    end
    if (fr && pd && ph != 1 && m_drop < 255)
      m_drop++;
    m_start = 0;
    if (ph == 0) begin
      m_pend = pd | fr;
      if (pd) begin
        m_phase = 1;
        m_start = 1;
      end else if (g >= 0) begin
        m_ptr = (g + 1) % N;
      end
    end else if (ph == 1) begin
      m_pend  = fr;
      m_timer = 0;
      m_phase = 2;
      m_busy  = 1;
    end else begin
      m_pend = pd | fr;
      if (fd) begin
        m_phase = 0;
        m_busy  = 0;
      end else if (m_timer == TO - 1) begin
        m_phase = 0;
        m_busy  = 0;
        m_tmo   = 1;
      end
      m_timer++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wr_en"}, vram_wr_en, 0);
    check({tag, "_addr"}, vram_wr_addr, 0);
    check({tag, "_data"}, vram_wr_data, 0);
    check({tag, "_start"}, frame_start, 0);
    check({tag, "_busy"}, render_busy, 0);
    check({tag, "_drop"}, dropped_frames, 0);
    check({tag, "_tmo"}, render_timeout, 0);
    check({tag, "_ready"}, bus.ready, 0);
  endtask

  task automatic reset_mid(input string tag);
    bus.valid  = '0;
    frame_req  = 1'b0;
    frame_done = 1'b0;
    rst_n      = 1'b0;
    #1;
    check_zero(tag);
    model_reset();
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.valid  = '0;
    bus.addr   = '0;
    bus.data   = '0;
    frame_req  = 1'b0;
    frame_done = 1'b0;
    model_reset();
    #2;
    check_zero("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) step(3'b111, 0, 0);
    step(3'b010, 0, 0);
    step(3'b000, 0, 0);

    step(3'b001, 1, 0);
    for (int i = 0; i < 24; i++)
      step(3'b001, 0, (i == 21));

    step(3'b000, 1, 0);
    step(3'b000, 0, 0);
    step(3'b000, 0, 0);
    step(3'b000, 1, 0);
    step(3'b000, 0, 0);
    step(3'b000, 1, 0);
    step(3'b000, 1, 0);
    step(3'b000, 0, 1);
    for (int i = 0; i < 8; i++)
      step(3'b000, 0, (i == 5));
    for (int i = 0; i < 30; i++)
      step(3'b000, 0, 0);

    step(3'b000, 1, 0);
    for (int i = 0; i < 24; i++)
      step(3'b000, 0, 0);
    step(3'b011, 1, 0);
    for (int i = 0; i < 10; i++)
      step(3'b011, 0, (i == 6));

    step(3'b001, 0, 0);
    reset_mid("rst_wr");
    step(3'b000, 1, 0);
    step(3'b000, 0, 0);
    step(3'b000, 0, 0);
    step(3'b100, 0, 0);
    reset_mid("rst_render");
    for (int i = 0; i < 4; i++) step(3'b111, 0, 0);

    for (int i = 0; i < 400; i++)
      step(3'($urandom_range(0, 7)), 1,
           ($urandom_range(0, 9) == 0));
    for (int i = 0; i < 1500; i++)
      step(3'($urandom_range(0, 7)),
           ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 9) == 0));

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
